time_date_ctrl: RTL and testbench

- Timekeeping and set-mode controller for the millennium clock.
- Consumes the 1 s and 0.5 s square waves from the clock divider and two debounced push-buttons (mode, increment).
- Advances a sec/min/hour/day/month/year register set with full calendar rollover.
- Sequences a user set mode that edits one field at a time and drives per-field blink masks for the display driver.

---
 rtl/time_date_pkg.sv | 51 +++++
 rtl/days_in_month.sv | 38 +++
 rtl/time_date_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_time_date_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_date_pkg.sv
// Shared types and constants for the millennium-clock timekeeping controller.
package time_date_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned DAY_W   = 5;
    localparam int unsigned MON_W   = 4;
    localparam int unsigned YEAR_W  = 14;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned MASK_W  = 6;

    // State encoding doubles as the set_field output encoding.
    typedef enum logic [FIELD_W-1:0] {
        ST_RUN      = 3'd0,
        ST_SET_SEC  = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_HOUR = 3'd3,
        ST_SET_DAY  = 3'd4,
        ST_SET_MON  = 3'd5,
        ST_SET_YEAR = 3'd6
    } state_e;

    // Field range limits.
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MON_W-1:0]  MON_MAX  = 4'd12;

    // blank_mask bit positions.
    localparam int unsigned BLANK_SEC  = 0;
    localparam int unsigned BLANK_MIN  = 1;
    localparam int unsigned BLANK_HOUR = 2;
    localparam int unsigned BLANK_DAY  = 3;
    localparam int unsigned BLANK_MON  = 4;
    localparam int unsigned BLANK_YEAR = 5;

    // Mode-button sequence: RUN -> SEC -> MIN -> HOUR -> DAY -> MON -> YEAR -> RUN.
    function automatic state_e next_set_state(input state_e s);
        case (s)
            ST_RUN:      return ST_SET_SEC;
            ST_SET_SEC:  return ST_SET_MIN;
            ST_SET_MIN:  return ST_SET_HOUR;
            ST_SET_HOUR: return ST_SET_DAY;
            ST_SET_DAY:  return ST_SET_MON;
            ST_SET_MON:  return ST_SET_YEAR;
            default:     return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/days_in_month.sv
// Days-in-month lookup. Leap-year February is built only when LEAP_YEAR_EN is defined.
module days_in_month
    import time_date_pkg::*;
(
    input  logic [MON_W-1:0]  month_i,
    input  logic [YEAR_W-1:0] year_i,
    output logic [DAY_W-1:0]  dim_o
);

    logic leap;

`ifdef LEAP_YEAR_EN
    // Gregorian rule; year 0 falls out as a leap year (0 % 400 == 0).
    always_comb begin
        leap = ((year_i % YEAR_W'(4)) == '0) &&
               (((year_i % YEAR_W'(100)) != '0) || ((year_i % YEAR_W'(400)) == '0));
    end
`else
    logic unused_year;

    // February is fixed at 28 days; the year has no effect.
    always_comb begin
        leap        = 1'b0;
        unused_year = ^year_i;
    end
`endif

    // Month-length table.
    always_comb begin
        dim_o = 5'd31;
        case (month_i)
            4'd2:                    dim_o = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim_o = 5'd30;
            default:                 dim_o = 5'd31;
        endcase
    end

endmodule

// File: rtl/time_date_ctrl.sv
// Timekeeping and set-mode controller: calendar counters, mode FSM, blink masks.
// Optional macro LEAP_YEAR_EN enables leap-year February (see days_in_month).
module time_date_ctrl
    import time_date_pkg::*;
#(
    parameter int unsigned YEAR_RESET  = 2000,
    parameter int unsigned YEAR_MAX    = 9999,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              clk_1s_in,
    input  logic              clk_0_5s_in,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  month,
    output logic [YEAR_W-1:0] year,
    output logic [FIELD_W-1:0] set_field,
    output logic [MASK_W-1:0] blank_mask,
    output logic              sec_pulse
);

    localparam int unsigned SYNC_N   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned N_IN     = 4;
    localparam int unsigned N_EDGE   = 3;
    localparam int unsigned IN_TICK  = 0;
    localparam int unsigned IN_MODE  = 1;
    localparam int unsigned IN_INC   = 2;
    localparam int unsigned IN_BLINK = 3;

    localparam logic [YEAR_W-1:0] YEAR_LAST  = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] YEAR_START = YEAR_W'(YEAR_RESET);
    localparam logic [DAY_W-1:0]  DAY_ONE    = 5'd1;
    localparam logic [MON_W-1:0]  MON_ONE    = 4'd1;

    logic [SYNC_N-1:0][N_IN-1:0] sync_q;
    logic [N_IN-1:0]             sync_last;
    logic [N_EDGE-1:0]           edge_q;
    logic                        tick;
    logic                        mode_p;
    logic                        inc_p;
    logic                        blink;

    state_e state_q, state_d;

    logic [SEC_W-1:0]  sec_q,   sec_d;
    logic [MIN_W-1:0]  min_q,   min_d;
    logic [HOUR_W-1:0] hour_q,  hour_d;
    logic [DAY_W-1:0]  day_q,   day_d, day_n;
    logic [MON_W-1:0]  month_q, month_d;
    logic [YEAR_W-1:0] year_q,  year_d, year_inc;
    logic [MASK_W-1:0] blank_q, blank_d;
    logic              sec_pulse_q, sec_pulse_d;

    logic [DAY_W-1:0]  dim_cur;
    logic [DAY_W-1:0]  dim_new;

    // Input synchronizers plus the edge-detect history flop.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= {clk_0_5s_in, btn_inc, btn_mode, clk_1s_in};
            for (int unsigned i = 1; i < SYNC_N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edge_q <= sync_last[N_EDGE-1:0];
        end
    end

    assign sync_last = sync_q[SYNC_N-1];
    assign tick      = sync_last[IN_TICK] & ~edge_q[IN_TICK];
    assign mode_p    = sync_last[IN_MODE] & ~edge_q[IN_MODE];
    assign inc_p     = sync_last[IN_INC]  & ~edge_q[IN_INC];
    assign blink     = sync_last[IN_BLINK];

    // Month length for the current date (day rollover / day edit wrap).
    days_in_month u_dim_cur (
        .month_i (month_q),
        .year_i  (year_q),
        .dim_o   (dim_cur)
    );

    // Month length for the date being written (day clamp).
    days_in_month u_dim_new (
        .month_i (month_d),
        .year_i  (year_d),
        .dim_o   (dim_new)
    );

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= DAY_ONE;
            month_q     <= MON_ONE;
            year_q      <= YEAR_START;
            blank_q     <= '0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            blank_q     <= blank_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    // Mode FSM next state: each mode strobe steps to the next field.
    always_comb begin
        state_d = state_q;
        if (mode_p) begin
            state_d = next_set_state(state_q);
        end
    end

    // Year successor with wrap past the last valid year.
    assign year_inc = (year_q >= YEAR_LAST) ? '0 : year_q + YEAR_W'(1);

    // Time update: full carry chain on tick in RUN, single-field edit in set states.
    always_comb begin
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        day_n       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        sec_pulse_d = 1'b0;

        if (tick && (state_q == ST_RUN)) begin
            sec_pulse_d = 1'b1;
            if (sec_q >= SEC_MAX) begin
                sec_d = '0;
                if (min_q >= MIN_MAX) begin
                    min_d = '0;
                    if (hour_q >= HOUR_MAX) begin
                        hour_d = '0;
                        if (day_q >= dim_cur) begin
                            day_n = DAY_ONE;
                            if (month_q >= MON_MAX) begin
                                month_d = MON_ONE;
                                year_d  = year_inc;
                            end else begin
                                month_d = month_q + MON_W'(1);
                            end
                        end else begin
                            day_n = day_q + DAY_W'(1);
                        end
                    end else begin
                        hour_d = hour_q + HOUR_W'(1);
                    end
                end else begin
                    min_d = min_q + MIN_W'(1);
                end
            end else begin
                sec_d = sec_q + SEC_W'(1);
            end
        end else if (inc_p && !mode_p) begin
            case (state_q)
                ST_SET_SEC:  sec_d   = (sec_q  >= SEC_MAX)  ? '0 : sec_q  + SEC_W'(1);
                ST_SET_MIN:  min_d   = (min_q  >= MIN_MAX)  ? '0 : min_q  + MIN_W'(1);
                ST_SET_HOUR: hour_d  = (hour_q >= HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
                ST_SET_DAY:  day_n   = (day_q  >= dim_cur)  ? DAY_ONE : day_q + DAY_W'(1);
                ST_SET_MON:  month_d = (month_q >= MON_MAX) ? MON_ONE : month_q + MON_W'(1);
                ST_SET_YEAR: year_d  = year_inc;
                default:     ;
            endcase
        end
    end

    // Pull day back to the last valid day when month or year shortens the month.
    assign day_d = (day_n > dim_new) ? dim_new : day_n;

    // Blink mask follows the field selected by the upcoming state.
    always_comb begin
        blank_d = '0;
        case (state_d)
            ST_SET_SEC:  blank_d[BLANK_SEC]  = blink;
            ST_SET_MIN:  blank_d[BLANK_MIN]  = blink;
            ST_SET_HOUR: blank_d[BLANK_HOUR] = blink;
            ST_SET_DAY:  blank_d[BLANK_DAY]  = blink;
            ST_SET_MON:  blank_d[BLANK_MON]  = blink;
            ST_SET_YEAR: blank_d[BLANK_YEAR] = blink;
            default:     ;
        endcase
    end

    assign sec        = sec_q;
    assign min        = min_q;
    assign hour       = hour_q;
    assign day        = day_q;
    assign month      = month_q;
    assign year       = year_q;
    assign set_field  = state_q;
    assign blank_mask = blank_q;
    assign sec_pulse  = sec_pulse_q;

endmodule

// File: tb/tb_time_date_ctrl.sv
// Scoreboard bench for time_date_ctrl: calendar rollover, set mode, leap years, races, reset.
module tb_time_date_ctrl;

    localparam int unsigned SS = 2;
    localparam int unsigned YR = 2000;
`ifdef LEAP_YEAR_EN
    localparam bit LEAP_ON = 1'b1;
`else
    localparam bit LEAP_ON = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        reset_n;
    logic        clk_1s_in;
    logic        clk_0_5s_in;
    logic        btn_mode;
    logic        btn_inc;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;
    logic [2:0]  set_field;
    logic [5:0]  blank_mask;
    logic        sec_pulse;

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_q[$];

    // Reference model of the calendar and mode state.
    int m_year, m_mon, m_day, m_hour, m_min, m_sec, m_state;

    time_date_ctrl #(
        .YEAR_RESET  (YR),
        .YEAR_MAX    (9999),
        .SYNC_STAGES (SS)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .clk_1s_in   (clk_1s_in),
        .clk_0_5s_in (clk_0_5s_in),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .day         (day),
        .month       (month),
        .year        (year),
        .set_field   (set_field),
        .blank_mask  (blank_mask),
        .sec_pulse   (sec_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic int ref_dim(input int mo, input int yr);
        bit leap;
        leap = ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0);
        if (mo == 2) return (LEAP_ON && leap) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [39:0] pack(input int y, input int mo, input int d,
                                         input int h, input int mi, input int s);
        return {14'(y), 4'(mo), 5'(d), 5'(h), 6'(mi), 6'(s)};
    endfunction

    function automatic logic [39:0] m_snap();
        return pack(m_year, m_mon, m_day, m_hour, m_min, m_sec);
    endfunction

    function automatic logic [39:0] dut_now();
        return {year, month, day, hour, min, sec};
    endfunction

    function automatic string fmt(input logic [39:0] v);
        return $sformatf("%0d-%0d-%0d %0d:%0d:%0d", v[39:26], v[25:22], v[21:17],
                         v[16:12], v[11:6], v[5:0]);
    endfunction

    function automatic void m_tick();
        if (m_sec < 59) begin m_sec++; return; end
        m_sec = 0;
        if (m_min < 59) begin m_min++; return; end
        m_min = 0;
        if (m_hour < 23) begin m_hour++; return; end
        m_hour = 0;
        if (m_day < ref_dim(m_mon, m_year)) begin m_day++; return; end
        m_day = 1;
        if (m_mon < 12) begin m_mon++; return; end
        m_mon  = 1;
        m_year = (m_year == 9999) ? 0 : m_year + 1;
    endfunction

    function automatic void m_inc();
        case (m_state)
            1: m_sec  = (m_sec + 1) % 60;
            2: m_min  = (m_min + 1) % 60;
            3: m_hour = (m_hour + 1) % 24;
            4: m_day  = (m_day % ref_dim(m_mon, m_year)) + 1;
            5: m_mon  = (m_mon % 12) + 1;
            6: m_year = (m_year + 1) % 10000;
            default: ;
        endcase
        if (m_day > ref_dim(m_mon, m_year)) m_day = ref_dim(m_mon, m_year);
    endfunction

    function automatic void m_apply(input bit t, input bit m, input bit i);
        if (t && m_state == 0) m_tick();
        if (i && !m && m_state != 0) m_inc();
        if (m) m_state = (m_state == 6) ? 0 : m_state + 1;
    endfunction

    function automatic int m_cur();
        case (m_state)
            1: return m_sec;
            2: return m_min;
            3: return m_hour;
            4: return m_day;
            5: return m_mon;
            6: return m_year;
            default: return -1;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic settle();
        cyc(SS + 4);
    endtask

    // One-cycle-high, one-cycle-low pulse on any combination of tick/mode/inc.
    task automatic pulse(input bit t, input bit m, input bit i);
        @(negedge sys_clk);
        clk_1s_in = t; btn_mode = m; btn_inc = i;
        m_apply(t, m, i);
        @(negedge sys_clk);
        clk_1s_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic goto_state(input int target);
        for (int k = 0; k < 8; k++) begin
            if (m_state == target) break;
            pulse(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic inc_to(input int target);
        for (int k = 0; k < 10001; k++) begin
            if (m_cur() == target) break;
            pulse(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic set_time(input int y, input int mo, input int d,
                            input int h, input int mi, input int s);
        goto_state(1); inc_to(s);
        goto_state(2); inc_to(mi);
        goto_state(3); inc_to(h);
        goto_state(5); inc_to(mo);
        goto_state(6); inc_to(y);
        goto_state(4); inc_to(d);
        goto_state(0);
        settle();
    endtask

    // Tick (optionally with mode) and watch a bounded window for sec_pulse.
    task automatic tick_wait(input bit with_mode, output bit seen);
        seen = 1'b0;
        @(negedge sys_clk);
        clk_1s_in = 1'b1; btn_mode = with_mode;
        m_apply(1'b1, with_mode, 1'b0);
        for (int c = 1; c <= int'(SS) + 4; c++) begin
            @(negedge sys_clk);
            if (sec_pulse === 1'b1) seen = 1'b1;
            if (c == 1) begin clk_1s_in = 1'b0; btn_mode = 1'b0; end
        end
    endtask

    task automatic test_reset();
        logic [39:0] got;
        reset_n = 1'b0; clk_1s_in = 1'b0; clk_0_5s_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        m_year = YR; m_mon = 1; m_day = 1; m_hour = 0; m_min = 0; m_sec = 0; m_state = 0;
        cyc(3);
        got = dut_now();
        total++; if (got !== pack(YR, 1, 1, 0, 0, 0)) begin bad++;
            $display("FAIL reset_time: got %s want %s", fmt(got), fmt(pack(YR, 1, 1, 0, 0, 0))); end
        total++; if (set_field !== 3'd0) begin bad++;
            $display("FAIL reset_field: got %0d want 0", set_field); end
        total++; if (blank_mask !== 6'd0) begin bad++;
            $display("FAIL reset_blank: got %b want 000000", blank_mask); end
        total++; if (sec_pulse !== 1'b0) begin bad++;
            $display("FAIL reset_pulse: got %b want 0", sec_pulse); end
        reset_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_tick_latency();
        int pulses = 0;
        logic [39:0] got, want;
        for (int p = 0; p < 3; p++) begin
            @(negedge sys_clk);
            clk_1s_in = 1'b1;
            m_tick();
            exp_q.push_back(m_snap());
            for (int c = 1; c <= int'(SS) + 4; c++) begin
                @(negedge sys_clk);
                if (sec_pulse === 1'b1) begin
                    pulses++;
                    total++; if (c != int'(SS) + 1) begin bad++;
                        $display("FAIL tick_latency: got %0d cycles want %0d", c, SS + 1); end
                    got  = dut_now();
                    want = exp_q.pop_front();
                    total++; if (got !== want) begin bad++;
                        $display("FAIL tick_time: got %s want %s", fmt(got), fmt(want)); end
                end
                if (c == 1) clk_1s_in = 1'b0;
            end
        end
        total++; if (pulses != 3) begin bad++;
            $display("FAIL tick_pulse_count: got %0d want 3", pulses); end
        total++; if (sec !== 6'd3) begin bad++;
            $display("FAIL tick_sec: got %0d want 3", sec); end
    endtask

    task automatic test_rollover();
        bit seen;
        logic [39:0] got, want;
        set_time(9999, 12, 31, 23, 59, 59);
        got = dut_now();
        total++; if (got !== pack(9999, 12, 31, 23, 59, 59)) begin bad++;
            $display("FAIL preload_9999: got %s want %s", fmt(got), fmt(pack(9999, 12, 31, 23, 59, 59))); end
        exp_q.push_back(pack(0, 1, 1, 0, 0, 0));
        tick_wait(1'b0, seen);
        total++; if (!seen) begin bad++;
            $display("FAIL rollover_pulse: got none want one sec_pulse"); end
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (got !== want) begin bad++;
            $display("FAIL rollover_time: got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_leap_2024();
        bit seen;
        logic [39:0] got, want;
        set_time(2024, 2, 28, 23, 59, 59);
        exp_q.push_back(LEAP_ON ? pack(2024, 2, 29, 0, 0, 0) : pack(2024, 3, 1, 0, 0, 0));
        tick_wait(1'b0, seen);
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (!seen || got !== want) begin bad++;
            $display("FAIL leap_2024: got %s pulse=%0d want %s", fmt(got), seen, fmt(want)); end
    endtask

    task automatic test_month_clamp();
        logic [39:0] got, want;
        set_time(2024, 1, 31, 12, 0, 0);
        goto_state(5);
        settle();
        total++; if (set_field !== 3'd5) begin bad++;
            $display("FAIL clamp_field: got %0d want 5", set_field); end
        pulse(1'b0, 1'b0, 1'b1);
        exp_q.push_back(pack(2024, 2, LEAP_ON ? 29 : 28, 12, 0, 0));
        settle();
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (got !== want) begin bad++;
            $display("FAIL month_clamp: got %s want %s", fmt(got), fmt(want)); end
        goto_state(0);
        settle();
    endtask

    task automatic test_leap_2100();
        bit seen;
        logic [39:0] got, want;
        set_time(2100, 2, 28, 23, 59, 59);
        exp_q.push_back(pack(2100, 3, 1, 0, 0, 0));
        tick_wait(1'b0, seen);
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (!seen || got !== want) begin bad++;
            $display("FAIL leap_2100: got %s pulse=%0d want %s", fmt(got), seen, fmt(want)); end
    endtask

    task automatic test_set_min();
        int npulse = 0;
        int hour_before;
        logic [39:0] got, want;
        goto_state(2);
        inc_to(59);
        hour_before = m_hour;
        pulse(1'b0, 1'b0, 1'b1);
        exp_q.push_back(m_snap());
        settle();
        total++; if (set_field !== 3'd2) begin bad++;
            $display("FAIL setmin_field: got %0d want 2", set_field); end
        total++; if (min !== 6'd0 || hour !== 5'(hour_before)) begin bad++;
            $display("FAIL setmin_wrap: got min=%0d hour=%0d want min=0 hour=%0d", min, hour, hour_before); end
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk); clk_1s_in = 1'b1;
            @(negedge sys_clk); clk_1s_in = 1'b0;
            for (int c = 0; c < int'(SS) + 3; c++) begin
                @(negedge sys_clk);
                if (sec_pulse === 1'b1) npulse++;
            end
        end
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (got !== want || npulse != 0) begin bad++;
            $display("FAIL setmin_frozen: got %s pulses=%0d want %s pulses=0", fmt(got), npulse, fmt(want)); end
        clk_0_5s_in = 1'b1; settle();
        total++; if (blank_mask !== 6'b000010) begin bad++;
            $display("FAIL setmin_blank_on: got %b want 000010", blank_mask); end
        clk_0_5s_in = 1'b0; settle();
        total++; if (blank_mask !== 6'b000000) begin bad++;
            $display("FAIL setmin_blank_off: got %b want 000000", blank_mask); end
        clk_0_5s_in = 1'b1;
        goto_state(0);
        settle();
        total++; if (blank_mask !== 6'b000000 || set_field !== 3'd0) begin bad++;
            $display("FAIL run_blank: got mask=%b field=%0d want mask=000000 field=0", blank_mask, set_field); end
        clk_0_5s_in = 1'b0;
        settle();
    endtask

    task automatic test_simultaneous();
        bit seen;
        logic [39:0] got, want;
        goto_state(3);
        settle();
        exp_q.push_back(m_snap());
        pulse(1'b0, 1'b1, 1'b1);
        settle();
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (set_field !== 3'd4 || got !== want) begin bad++;
            $display("FAIL mode_inc_race: got field=%0d %s want field=4 %s", set_field, fmt(got), fmt(want)); end
        goto_state(0);
        settle();
        tick_wait(1'b1, seen);
        exp_q.push_back(m_snap());
        settle();
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (!seen || set_field !== 3'd1 || got !== want) begin bad++;
            $display("FAIL tick_mode_run: got field=%0d pulse=%0d %s want field=1 pulse=1 %s",
                     set_field, seen, fmt(got), fmt(want)); end
        goto_state(6);
        settle();
        exp_q.push_back(m_snap());
        tick_wait(1'b1, seen);
        settle();
        got  = dut_now();
        want = exp_q.pop_front();
        total++; if (seen || set_field !== 3'd0 || got !== want) begin bad++;
            $display("FAIL tick_mode_year: got field=%0d pulse=%0d %s want field=0 pulse=0 %s",
                     set_field, seen, fmt(got), fmt(want)); end
    endtask

    task automatic test_reset_in_set();
        logic [39:0] got;
        goto_state(6);
        clk_0_5s_in = 1'b1;
        settle();
        total++; if (blank_mask !== 6'b100000 || set_field !== 3'd6) begin bad++;
            $display("FAIL year_blank: got mask=%b field=%0d want mask=100000 field=6", blank_mask, set_field); end
        #2;
        reset_n = 1'b0;
        #1;
        got = dut_now();
        total++; if (got !== pack(YR, 1, 1, 0, 0, 0) || set_field !== 3'd0 ||
                     blank_mask !== 6'd0 || sec_pulse !== 1'b0) begin bad++;
            $display("FAIL async_reset: got %s field=%0d mask=%b pulse=%b want %s field=0 mask=000000 pulse=0",
                     fmt(got), set_field, blank_mask, sec_pulse, fmt(pack(YR, 1, 1, 0, 0, 0))); end
        clk_0_5s_in = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_tick_latency();
        test_rollover();
        test_leap_2024();
        test_month_clamp();
        test_leap_2100();
        test_set_min();
        test_simultaneous();
        test_reset_in_set();
        total++; if (exp_q.size() != 0) begin bad++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
